sram_port_arbiter: RTL and testbench

- Two-port arbiter and sequencer for the single external 256Kx16 asynchronous SRAM.
- Shares the SRAM between a CPU-side requester (port A, SPI slave path) and a radio-side requester (port B, wireless path).
- Grants one single-word access at a time, round-robin, and drives the CE_n/OE_n/WE_n/LB_n/UB_n/address/data timing.
- Returns a one-cycle ack to the granted port; FIFO pointer bookkeeping stays in the requesters.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_rr_grant.sv | 36 +++
 rtl/sram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/sram_rr_grant.sv
// Two-input round-robin picker; remembers the last granted port.
module sram_rr_grant
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_take,
    output logic o_valid,
    output logic o_id
);

    logic r_last;

    always_comb begin
        o_valid = i_req_a | i_req_b;
        if (i_req_a && i_req_b) begin
            o_id = ~r_last;
        end else if (i_req_a) begin
            o_id = PORT_A;
        end else begin
            o_id = PORT_B;
        end
    end

    // Reset to B so that A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_B;
        end else if (i_take && o_valid) begin
            r_last <= o_id;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates two single-word requesters onto one async SRAM and sequences its strobes.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              hint_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              hint_b,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] Dout,
    output logic              CE_n,
    output logic              OE_n,
    output logic              WE_n,
    output logic              LB_n,
    output logic              UB_n
);

    arb_state_t        r_state;
    logic              r_owner;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_dq_oe;
    logic [7:0]        r_cnt;
    logic              r_ack_a, r_ack_b, r_hint_a, r_hint_b;
    logic [DATA_W-1:0] r_rdata_a, r_rdata_b;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_ce_n, r_oe_n, r_we_n, r_lb_n, r_ub_n;

    logic              w_gnt_valid;
    logic              w_gnt_id;
    logic              w_take;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_take      = (r_state == IDLE);
    assign w_sel_we    = (w_gnt_id == PORT_A) ? we_a    : we_b;
    assign w_sel_addr  = (w_gnt_id == PORT_A) ? addr_a  : addr_b;
    assign w_sel_wdata = (w_gnt_id == PORT_A) ? wdata_a : wdata_b;

    sram_rr_grant u_grant (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req_a (req_a),
        .i_req_b (req_b),
        .i_take  (w_take),
        .o_valid (w_gnt_valid),
        .o_id    (w_gnt_id)
    );

    // Strobes are registered one state ahead: the values for a state are loaded on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= PORT_A;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_dq_oe    <= 1'b0;
            r_cnt      <= '0;
            r_ack_a    <= 1'b0;
            r_ack_b    <= 1'b0;
            r_hint_a   <= 1'b0;
            r_hint_b   <= 1'b0;
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            r_mem_addr <= '0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_lb_n     <= 1'b1;
            r_ub_n     <= 1'b1;
        end else begin
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_owner    <= w_gnt_id;
                        r_we       <= w_sel_we;
                        r_wdata    <= w_sel_wdata;
                        r_mem_addr <= w_sel_addr;
                        r_hint_a   <= (w_gnt_id == PORT_A);
                        r_hint_b   <= (w_gnt_id == PORT_B);
                        r_ce_n     <= 1'b0;
                        r_lb_n     <= 1'b0;
                        r_ub_n     <= 1'b0;
                        r_oe_n     <= w_sel_we;
                        r_dq_oe    <= w_sel_we;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    r_we_n  <= ~r_we;
                    r_cnt   <= '0;
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (r_cnt == 8'(WAIT_CYC)) begin
                        r_we_n <= 1'b1;
                        r_oe_n <= 1'b1;
                        if (r_owner == PORT_A) begin
                            r_ack_a <= 1'b1;
                            if (!r_we) r_rdata_a <= Dout;
                        end else begin
                            r_ack_b <= 1'b1;
                            if (!r_we) r_rdata_b <= Dout;
                        end
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE: begin
                    r_hint_a <= 1'b0;
                    r_hint_b <= 1'b0;
                    r_ce_n   <= 1'b1;
                    r_lb_n   <= 1'b1;
                    r_ub_n   <= 1'b1;
                    r_dq_oe  <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Dout     = r_dq_oe ? r_wdata : 'z;
    assign ack_a    = r_ack_a;
    assign ack_b    = r_ack_b;
    assign hint_a   = r_hint_a;
    assign hint_b   = r_hint_b;
    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;
    assign mem_addr = r_mem_addr;
    assign CE_n     = r_ce_n;
    assign OE_n     = r_oe_n;
    assign WE_n     = r_we_n;
    assign LB_n     = r_lb_n;
    assign UB_n     = r_ub_n;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: write/read timing, fairness, reset abort, long-wait build.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_a = 0, we_a = 0, req_b = 0, we_b = 0;
    logic [17:0] addr_a = '0, addr_b = '0;
    logic [15:0] wdata_a = '0, wdata_b = '0;
    logic        ack_a, ack_b, hint_a, hint_b;
    logic [15:0] rdata_a, rdata_b;
    logic [17:0] mem_addr;
    wire  [15:0] w_dout;
    logic        CE_n, OE_n, WE_n, LB_n, UB_n;

    logic        req_a3 = 0;
    logic [17:0] addr_a3 = '0;
    logic [15:0] wdata_a3 = '0;
    logic        ack_a3, ack_b3, hint_a3, hint_b3;
    logic [15:0] rdata_a3, rdata_b3;
    logic [17:0] mem_addr3;
    wire  [15:0] w_dout3;
    logic        CE_n3, OE_n3, WE_n3, LB_n3, UB_n3;

    logic [15:0] mem [256];
    logic        probe = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // SRAM model; probe drives a marker to prove the DUT has released the bus.
    assign w_dout = probe ? 16'h5A5A :
                    (!CE_n && !OE_n && WE_n) ? mem[mem_addr[7:0]] : 'z;
    always @(posedge WE_n) if (!CE_n) mem[mem_addr[7:0]] <= w_dout;

    sram_port_arbiter u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a), .hint_a(hint_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b), .hint_b(hint_b),
        .mem_addr(mem_addr), .Dout(w_dout),
        .CE_n(CE_n), .OE_n(OE_n), .WE_n(WE_n), .LB_n(LB_n), .UB_n(UB_n)
    );

    sram_port_arbiter #(.WAIT_CYC(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a3), .we_a(1'b1), .addr_a(addr_a3), .wdata_a(wdata_a3),
        .ack_a(ack_a3), .rdata_a(rdata_a3), .hint_a(hint_a3),
        .req_b(1'b0), .we_b(1'b0), .addr_b(18'h0), .wdata_b(16'h0),
        .ack_b(ack_b3), .rdata_b(rdata_b3), .hint_b(hint_b3),
        .mem_addr(mem_addr3), .Dout(w_dout3),
        .CE_n(CE_n3), .OE_n(OE_n3), .WE_n(WE_n3), .LB_n(LB_n3), .UB_n(UB_n3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        step();
        probe = 1'b1;
        #1;
        chk("rst_dout_hiz", w_dout, 16'h5A5A);
        probe = 1'b0;
        chk("rst_ack_a", ack_a, 0);   chk("rst_ack_b", ack_b, 0);
        chk("rst_hint_a", hint_a, 0); chk("rst_hint_b", hint_b, 0);
        chk("rst_rdata_a", rdata_a, 0); chk("rst_rdata_b", rdata_b, 0);
        chk("rst_strobes", {CE_n, OE_n, WE_n, LB_n, UB_n}, 5'b11111);
        chk("rst_addr", mem_addr, 0);
        step();
        rst_n = 1'b1;
        step();

        // Port A write of A5A5 to 0x00010
        req_a = 1; we_a = 1; addr_a = 18'h00010; wdata_a = 16'hA5A5;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 4) req_a = 0;
            chk($sformatf("wr_we_n_c%0d", k), WE_n, (k == 2 || k == 3) ? 0 : 1);
            chk($sformatf("wr_oe_n_c%0d", k), OE_n, 1);
            chk($sformatf("wr_ack_a_c%0d", k), ack_a, (k == 4) ? 1 : 0);
            chk($sformatf("wr_hint_a_c%0d", k), hint_a, (k <= 4) ? 1 : 0);
            chk($sformatf("wr_ce_n_c%0d", k), CE_n, (k <= 4) ? 0 : 1);
            if (k <= 4) begin
                chk($sformatf("wr_dout_c%0d", k), w_dout, 16'hA5A5);
                chk($sformatf("wr_addr_c%0d", k), mem_addr, 18'h00010);
                chk($sformatf("wr_lbub_c%0d", k), {LB_n, UB_n}, 2'b00);
            end else begin
                probe = 1'b1;
                #1;
                chk("wr_dout_released", w_dout, 16'h5A5A);
                probe = 1'b0;
            end
        end

        // Port B reads it back
        req_b = 1; we_b = 0; addr_b = 18'h00010;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 4) req_b = 0;
            chk($sformatf("rd_oe_n_c%0d", k), OE_n, (k <= 3) ? 0 : 1);
            chk($sformatf("rd_we_n_c%0d", k), WE_n, 1);
            chk($sformatf("rd_ack_b_c%0d", k), ack_b, (k == 4) ? 1 : 0);
            chk($sformatf("rd_ack_a_c%0d", k), ack_a, 0);
            chk($sformatf("rd_hint_b_c%0d", k), hint_b, (k <= 4) ? 1 : 0);
            if (k == 4) chk("rd_rdata_b", rdata_b, 16'hA5A5);
        end

        // Continuous contention: A,B,A,B,... one access per 5 clocks
        req_a = 1; we_a = 0; addr_a = 18'h00001;
        req_b = 1; we_b = 0; addr_b = 18'h00002;
        for (int n = 0; n < 8; n++) begin
            for (int k = 1; k <= 5; k++) begin
                step();
                if (n == 7 && k == 4) begin req_a = 0; req_b = 0; end
                chk($sformatf("rr%0d_no_overlap_c%0d", n, k), hint_a & hint_b, 0);
                chk($sformatf("rr%0d_we_oe_c%0d", n, k), !WE_n && !OE_n, 0);
                if (k == 1) chk($sformatf("rr%0d_hint", n), {hint_a, hint_b}, (n % 2 == 0) ? 2'b10 : 2'b01);
                if (k == 4) chk($sformatf("rr%0d_ack", n), {ack_a, ack_b}, (n % 2 == 0) ? 2'b10 : 2'b01);
                if (k == 5) chk($sformatf("rr%0d_idle", n), {hint_a, hint_b, ack_a, ack_b}, 4'b0000);
            end
        end

        // Single requester B: back-to-back grants
        req_b = 1; addr_b = 18'h00010;
        for (int n = 0; n < 3; n++) begin
            for (int k = 1; k <= 5; k++) begin
                step();
                if (n == 2 && k == 4) req_b = 0;
                chk($sformatf("sb%0d_ack_a_c%0d", n, k), ack_a, 0);
                chk($sformatf("sb%0d_ack_b_c%0d", n, k), ack_b, (k == 4) ? 1 : 0);
                chk($sformatf("sb%0d_hint_b_c%0d", n, k), hint_b, (k <= 4) ? 1 : 0);
            end
        end

        // Reset during ACCESS of a write
        req_a = 1; we_a = 1; addr_a = 18'h00020; wdata_a = 16'h1234;
        step();
        step();
        chk("ab_pre_we_n", WE_n, 0);
        rst_n = 1'b0;
        probe = 1'b1;
        req_a = 0;
        #1;
        chk("ab_we_n", WE_n, 1);
        chk("ab_ce_n", CE_n, 1);
        chk("ab_dout_hiz", w_dout, 16'h5A5A);
        chk("ab_hint_a", hint_a, 0);
        probe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ab_no_ack_%0d", k), {ack_a, ack_b}, 2'b00);
        end
        rst_n = 1'b1;
        step();
        req_a = 1; we_a = 0; addr_a = 18'h00010;
        req_b = 1; we_b = 0; addr_b = 18'h00010;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) chk("ab_first_hint", {hint_a, hint_b}, 2'b10);
            if (k == 4) begin
                chk("ab_first_ack", {ack_a, ack_b}, 2'b10);
                req_a = 0; req_b = 0;
            end
        end
        step();
        step();
        step();
        step();

        // WAIT_CYC=3 build: ACCESS spans 4 clocks, ack at cycle 6
        req_a3 = 1; addr_a3 = 18'h00033; wdata_a3 = 16'hC3C3;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 6) req_a3 = 0;
            chk($sformatf("w3_we_n_c%0d", k), WE_n3, (k >= 2 && k <= 5) ? 0 : 1);
            chk($sformatf("w3_ack_c%0d", k), ack_a3, (k == 6) ? 1 : 0);
            if (k <= 6) begin
                chk($sformatf("w3_dout_c%0d", k), w_dout3, 16'hC3C3);
                chk($sformatf("w3_addr_c%0d", k), mem_addr3, 18'h00033);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
